// File: rtl/instr_mem_responder.sv
// Instruction-fetch memory responder: word RAM with program-load port, in-order
// fixed-latency read responses, outstanding-request limit and optional grant stalls.
module instr_mem_responder #(
  parameter int unsigned MEM_WORDS       = 4096,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
  parameter int unsigned READ_LATENCY    = 1,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned GNT_STALL_EVERY = 0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        load_we_i,
  input  logic [31:0] load_addr_i,
  input  logic [31:0] load_wdata_i,
  output logic [3:0]  outstanding_o
);

  localparam int unsigned AW      = $clog2(MEM_WORDS);
  localparam logic [3:0]  MAX_OUT = 4'(MAX_OUTSTANDING);

  logic [31:0]             r_mem [MEM_WORDS];
  logic [READ_LATENCY-1:0] r_pv;
  logic [READ_LATENCY-1:0] r_pe;
  logic [31:0]             r_pd [READ_LATENCY];
  logic [3:0]              r_outstanding;

  logic          w_stall_slot;
  logic          w_gnt;
  logic          w_rsp;
  logic          w_rd_hit;
  logic          w_ld_hit;
  logic [31:0]   w_rd_off;
  logic [31:0]   w_ld_off;
  logic [AW-1:0] w_rd_idx;
  logic [AW-1:0] w_ld_idx;
  logic          w_unused_lsbs;

  // Offsets wrap below BASE_ADDR, so one upper-bits test covers both bounds.
  assign w_rd_off      = instr_addr_i - BASE_ADDR;
  assign w_ld_off      = load_addr_i - BASE_ADDR;
  assign w_rd_hit      = (w_rd_off[31:AW+2] == '0);
  assign w_ld_hit      = (w_ld_off[31:AW+2] == '0);
  assign w_rd_idx      = w_rd_off[AW+1:2];
  assign w_ld_idx      = w_ld_off[AW+1:2];
  assign w_unused_lsbs = ^{w_rd_off[1:0], w_ld_off[1:0]};

  generate
    if (GNT_STALL_EVERY > 1) begin : g_stall
      localparam int unsigned SW   = $clog2(GNT_STALL_EVERY);
      localparam logic [SW-1:0] LAST = SW'(GNT_STALL_EVERY - 1);
      logic [SW-1:0] r_stall_cnt;

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          r_stall_cnt <= '0;
        end else if (r_stall_cnt == LAST) begin
          r_stall_cnt <= '0;
        end else begin
          r_stall_cnt <= r_stall_cnt + 1'b1;
        end
      end

      assign w_stall_slot = (r_stall_cnt == LAST);
    end else begin : g_no_stall
      assign w_stall_slot = 1'b0;
    end
  endgenerate

  // A response leaving this cycle frees its slot for a same-cycle grant.
  assign w_rsp = r_pv[READ_LATENCY-1];
  assign w_gnt = instr_req_i & ~w_stall_slot & ((r_outstanding < MAX_OUT) | w_rsp);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pv <= '0;
      r_pe <= '0;
      for (int unsigned i = 0; i < READ_LATENCY; i++) begin
        r_pd[i] <= '0;
      end
    end else begin
      r_pv[0] <= w_gnt;
      r_pe[0] <= w_gnt & ~w_rd_hit;
      r_pd[0] <= (w_gnt & w_rd_hit) ? r_mem[w_rd_idx] : '0;
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pe[i] <= r_pe[i-1];
        r_pd[i] <= r_pd[i-1];
      end
    end
  end

  // Same-edge load and read of one word: the read above sees the old value.
  always_ff @(posedge clk) begin
    if (load_we_i & w_ld_hit) begin
      r_mem[w_ld_idx] <= load_wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_outstanding <= '0;
    end else begin
      case ({w_gnt, w_rsp})
        2'b10:   r_outstanding <= r_outstanding + 4'd1;
        2'b01:   r_outstanding <= r_outstanding - 4'd1;
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  assign instr_gnt_o    = w_gnt;
  assign instr_rvalid_o = w_rsp;
  assign instr_err_o    = w_rsp & r_pe[READ_LATENCY-1];
  assign instr_rdata_o  = w_rsp ? r_pd[READ_LATENCY-1] : '0;
  assign outstanding_o  = r_outstanding;

endmodule
